// File: rtl/cs_measure_ctrl.sv
// cs_measure_ctrl: compressed-sensing measurement scheduler with one time-multiplexed adder.
// Optional CS_SAT_EN: saturating accumulation plus a sticky sat_flag output.
module cs_measure_ctrl #(
  parameter int DATA_W    = 12,
  parameter int ACC_W     = 24,
  parameter int N_SAMPLES = 256,
  parameter int M_MEAS    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         prbs_reseed,
  output logic                         prbs_step,
  input  logic [M_MEAS-1:0]            prbs_bits,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_W-1:0]     s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic signed [ACC_W-1:0]      m_data,
  output logic [$clog2(M_MEAS)-1:0]    m_index,
  output logic                         frame_done
`ifdef CS_SAT_EN
  ,
  output logic                         sat_flag
`endif
);
  localparam int RW = $clog2(M_MEAS);
  localparam int SW = $clog2(N_SAMPLES);
  typedef enum logic [2:0] {IDLE, WAIT_SAMPLE, ACCUM, STEP, DRAIN} state_t;
  state_t state, nxt;
  logic signed [ACC_W-1:0]  acc [M_MEAS];
  logic signed [DATA_W-1:0] x_reg;
  logic [SW-1:0]            sample_cnt;
  logic [RW-1:0]            row_idx, out_idx;
  logic signed [ACC_W-1:0]  x_ext, addend, acc_nxt;
  logic                     last_row, last_out, last_sample;
  assign last_row    = row_idx == RW'(M_MEAS - 1);
  assign last_out    = out_idx == RW'(M_MEAS - 1);
  assign last_sample = sample_cnt == SW'(N_SAMPLES - 1);
  assign x_ext  = ACC_W'(x_reg);
  assign addend = prbs_bits[row_idx] ? x_ext : -x_ext;
`ifdef CS_SAT_EN
  logic [ACC_W:0] sum;
  logic           clip;
  assign sum     = {acc[row_idx][ACC_W-1], acc[row_idx]} + {addend[ACC_W-1], addend};
  assign clip    = sum[ACC_W] ^ sum[ACC_W-1];
  // a differing carry-out and sign bit means the true sum left the ACC_W range
  assign acc_nxt = !clip ? sum[ACC_W-1:0] : sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                       : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign acc_nxt = acc[row_idx] + addend;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:        nxt = start ? WAIT_SAMPLE : IDLE;
      WAIT_SAMPLE: nxt = s_valid ? ACCUM : WAIT_SAMPLE;
      ACCUM:       nxt = last_row ? STEP : ACCUM;
      STEP:        nxt = last_sample ? DRAIN : WAIT_SAMPLE;
      DRAIN:       nxt = (m_ready && last_out) ? IDLE : DRAIN;
      default:     nxt = IDLE;
    endcase
  end
  always_comb begin
    busy        = state != IDLE;
    s_ready     = state == WAIT_SAMPLE;
    m_valid     = state == DRAIN;
    prbs_step   = state == STEP;
    prbs_reseed = state == IDLE && start;
    m_data      = acc[out_idx];
    m_index     = out_idx;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < M_MEAS; i++) acc[i] <= '0;
      x_reg      <= '0;
      sample_cnt <= '0;
      row_idx    <= '0;
      out_idx    <= '0;
      frame_done <= 1'b0;
`ifdef CS_SAT_EN
      sat_flag   <= 1'b0;
`endif
    end else begin
      frame_done <= state == DRAIN && m_ready && last_out;
      case (state)
        IDLE: if (start) begin
          for (int i = 0; i < M_MEAS; i++) acc[i] <= '0;
          sample_cnt <= '0;
`ifdef CS_SAT_EN
          sat_flag   <= 1'b0;
`endif
        end
        WAIT_SAMPLE: if (s_valid) begin
          x_reg   <= s_data;
          row_idx <= '0;
        end
        ACCUM: begin
          acc[row_idx] <= acc_nxt;
          row_idx      <= row_idx + 1'b1;
`ifdef CS_SAT_EN
          sat_flag     <= sat_flag | clip;
`endif
        end
        STEP: if (last_sample) out_idx <= '0;
              else             sample_cnt <= sample_cnt + 1'b1;
        DRAIN: if (m_ready) out_idx <= last_out ? '0 : out_idx + 1'b1;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_cs_measure_ctrl.sv
// tb_cs_measure_ctrl: directed scenario bench; a second instance with ACC_W=8 runs in lockstep
// on the same stimulus to exercise accumulator overflow.
module tb_cs_measure_ctrl;
  logic clk = 0, reset = 0, start = 0, s_valid = 0, m_ready = 0;
  logic [3:0] prbs_bits = '0;
  logic signed [7:0] s_data = '0;
  logic busy, prbs_reseed, prbs_step, s_ready, m_valid, frame_done;
  logic signed [11:0] m_data;
  logic [1:0] m_index;
  logic busy2, prbs_reseed2, prbs_step2, s_ready2, m_valid2, frame_done2;
  logic signed [7:0] m_data2;
  logic [1:0] m_index2;
`ifdef CS_SAT_EN
  logic sat_flag, sat_flag2;
`endif
  int errors = 0, checks = 0;
  int step_cnt = 0, done_cnt = 0, reseed_cnt = 0;
  int sready_viol, hold_viol;
  logic signed [7:0]  xs [4];
  logic signed [11:0] res [4];
  logic signed [7:0]  res2 [4];
  logic [1:0]         idx_seen [4];

  cs_measure_ctrl #(.DATA_W(8), .ACC_W(12), .N_SAMPLES(4), .M_MEAS(4)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .prbs_reseed(prbs_reseed),
    .prbs_step(prbs_step), .prbs_bits(prbs_bits), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_index(m_index), .frame_done(frame_done)
`ifdef CS_SAT_EN
    , .sat_flag(sat_flag)
`endif
  );

  cs_measure_ctrl #(.DATA_W(8), .ACC_W(8), .N_SAMPLES(4), .M_MEAS(4)) dut2 (
    .clk(clk), .reset(reset), .start(start), .busy(busy2), .prbs_reseed(prbs_reseed2),
    .prbs_step(prbs_step2), .prbs_bits(prbs_bits), .s_valid(s_valid), .s_ready(s_ready2),
    .s_data(s_data), .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2),
    .m_index(m_index2), .frame_done(frame_done2)
`ifdef CS_SAT_EN
    , .sat_flag(sat_flag2)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (prbs_step)   step_cnt++;
    if (frame_done)  done_cnt++;
    if (prbs_reseed) reseed_cnt++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Runs one full frame of xs[]; inputs change on negedges, outputs read #1 later.
  task automatic run_frame(input logic [3:0] bits, input bit gaps, input bit toggle, input bit spam);
    int n;
    logic signed [11:0] d;
    logic [1:0] ix;
    sready_viol = 0;
    hold_viol = 0;
    prbs_bits = bits;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 4; k++) begin
      if (gaps) repeat (k + 1) @(negedge clk);
      start = spam; s_valid = 1; s_data = xs[k]; n = 0; #1;
      while (!s_ready && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL sample_wait[%0d]: s_ready=%0b required 1", k, s_ready);
      end
      @(negedge clk); s_valid = 0;
      for (int i = 0; i < 5; i++) begin #1; if (s_ready) sready_viol++; @(negedge clk); end
      start = 0;
    end
    for (int j = 0; j < 4; j++) begin
      start = spam && j < 3; m_ready = 0; n = 0; #1;
      while (!m_valid && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) begin
        checks++; errors++;
        $display("FAIL drain_wait[%0d]: m_valid=%0b required 1", j, m_valid);
      end
      if (toggle) begin
        d = m_data; ix = m_index;
        @(negedge clk); #1;
        if (m_data !== d || m_index !== ix || m_valid !== 1'b1) hold_viol++;
      end
      res[m_index] = m_data; res2[m_index] = m_data2; idx_seen[j] = m_index;
      m_ready = 1;
      @(negedge clk);
    end
    m_ready = 0; start = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, s_ready, m_valid, prbs_step, prbs_reseed, frame_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b required 000000", {busy, s_ready, m_valid, prbs_step, prbs_reseed, frame_done});
    end
    checks++;
    if (m_data !== 12'sd0 || m_index !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: m_data=%0d m_index=%0d required 0 0", m_data, m_index);
    end
`ifdef CS_SAT_EN
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b required 0", sat_flag); end
`endif
    @(negedge clk); reset = 1;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_all_ones;
    int s0, d0;
    s0 = step_cnt; d0 = done_cnt;
    xs = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    run_frame(4'b1111, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== 12'sd10) begin errors++; $display("FAIL ones_data[%0d]: got %0d required 10", i, res[i]); end
      checks++;
      if (idx_seen[i] !== 2'(i)) begin errors++; $display("FAIL ones_index[%0d]: got %0d required %0d", i, idx_seen[i], i); end
    end
    checks++;
    if (step_cnt - s0 !== 4) begin errors++; $display("FAIL ones_steps: got %0d required 4", step_cnt - s0); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL ones_done: got %0d required 1", done_cnt - d0); end
    checks++;
    if (sready_viol !== 0) begin errors++; $display("FAIL ones_sready: got %0d cycles required 0", sready_viol); end
  endtask

  task automatic test_mixed_signs;
    logic signed [11:0] e [4];
    xs = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    e = '{12'sd10, -12'sd10, 12'sd10, -12'sd10};
    run_frame(4'b0101, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== e[i]) begin errors++; $display("FAIL mixed_data[%0d]: got %0d required %0d", i, res[i], e[i]); end
    end
    xs = '{8'sh80, 8'sh80, 8'sh80, 8'sh80};
    e = '{-12'sd512, 12'sd512, -12'sd512, 12'sd512};
    run_frame(4'b0101, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== e[i]) begin errors++; $display("FAIL minneg_data[%0d]: got %0d required %0d", i, res[i], e[i]); end
    end
  endtask

  task automatic test_backpressure;
    int d0;
    d0 = done_cnt;
    xs = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    run_frame(4'b1111, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== 12'sd10) begin errors++; $display("FAIL bp_data[%0d]: got %0d required 10", i, res[i]); end
    end
    checks++;
    if (hold_viol !== 0) begin errors++; $display("FAIL bp_hold: got %0d changes required 0", hold_viol); end
    checks++;
    if (sready_viol !== 0) begin errors++; $display("FAIL bp_sready: got %0d cycles required 0", sready_viol); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL bp_done: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_start_ignored;
    int r0, d0, s0;
    r0 = reseed_cnt; d0 = done_cnt; s0 = step_cnt;
    xs = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    run_frame(4'b1111, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== 12'sd10) begin errors++; $display("FAIL spam_data[%0d]: got %0d required 10", i, res[i]); end
    end
    checks++;
    if (reseed_cnt - r0 !== 1) begin errors++; $display("FAIL spam_reseed: got %0d required 1", reseed_cnt - r0); end
    checks++;
    if (step_cnt - s0 !== 4) begin errors++; $display("FAIL spam_steps: got %0d required 4", step_cnt - s0); end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL spam_done: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_reset_abort;
    int d0;
    d0 = done_cnt;
    prbs_bits = 4'b1111;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0; s_valid = 1; s_data = 8'sd5;
    @(negedge clk); s_valid = 0;
    repeat (5) @(negedge clk);
    s_valid = 1; s_data = 8'sd6;
    @(negedge clk); s_valid = 0;
    @(negedge clk);
    #1;
    checks++;
    if (m_data !== 12'sd11 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: m_data=%0d busy=%b required 11 1", m_data, busy);
    end
    reset = 0; #1;
    checks++;
    if ({busy, s_ready, m_valid, prbs_step, prbs_reseed, frame_done} !== 6'b0 || m_data !== 12'sd0 || m_index !== 2'd0) begin
      errors++;
      $display("FAIL abort_outputs: ctrl=%b m_data=%0d m_index=%0d required 0", {busy, s_ready, m_valid, prbs_step, prbs_reseed, frame_done}, m_data, m_index);
    end
    @(negedge clk); reset = 1;
    xs = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    run_frame(4'b1111, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res[i] !== 12'sd4) begin errors++; $display("FAIL abort_data[%0d]: got %0d required 4", i, res[i]); end
    end
    checks++;
    if (done_cnt - d0 !== 1) begin errors++; $display("FAIL abort_done: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_overflow;
    logic signed [7:0] e2;
`ifdef CS_SAT_EN
    e2 = 8'sd127;
`else
    e2 = -8'sd4;
`endif
    xs = '{8'sd127, 8'sd127, 8'sd127, 8'sd127};
    run_frame(4'b1111, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (res2[i] !== e2) begin errors++; $display("FAIL ovf8_data[%0d]: got %0d required %0d", i, res2[i], e2); end
      checks++;
      if (res[i] !== 12'sd508) begin errors++; $display("FAIL ovf12_data[%0d]: got %0d required 508", i, res[i]); end
    end
`ifdef CS_SAT_EN
    checks++;
    if (sat_flag2 !== 1'b1) begin errors++; $display("FAIL ovf_sat8: got %b required 1", sat_flag2); end
    checks++;
    if (sat_flag !== 1'b0) begin errors++; $display("FAIL ovf_sat12: got %b required 0", sat_flag); end
`endif
  endtask

  initial begin
    test_reset;
    test_all_ones;
    test_mixed_signs;
    test_backpressure;
    test_start_ignored;
    test_reset_abort;
    test_overflow;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
